// File: rtl/clkgen_bank.sv
// N-channel programmable clock-enable / PWM generator.
// Each channel has a double-buffered period and high time that apply on a period boundary.
module clkgen_bank #(
    parameter int unsigned    N          = 4,
    parameter int unsigned    W          = 32,
    parameter logic [W-1:0]   DEF_PERIOD = W'(50000000),
    parameter logic [W-1:0]   DEF_HIGH   = W'(25000000)
) (
    input  logic                                   clk,
    input  logic                                   rst_,
    input  logic [N-1:0]                           ena,
    input  logic                                   cfg_we,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]   cfg_ch,
    input  logic [W-1:0]                           cfg_period,
    input  logic [W-1:0]                           cfg_high,
    input  logic                                   cfg_sync,
    output logic                                   cfg_err,
    output logic [N-1:0]                           pend,
    output logic [N-1:0]                           gen,
    output logic [N-1:0]                           tick
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt_q  [N];
    logic [W-1:0] cnt_d  [N];
    logic [W-1:0] per_q  [N];
    logic [W-1:0] per_d  [N];
    logic [W-1:0] hi_q   [N];
    logic [W-1:0] hi_d   [N];
    logic [W-1:0] sper_q [N];
    logic [W-1:0] sper_d [N];
    logic [W-1:0] shi_q  [N];
    logic [W-1:0] shi_d  [N];
    logic [N-1:0] act_q;
    logic [N-1:0] pend_d;
    logic [N-1:0] gen_d;
    logic [N-1:0] tick_d;
    logic [N-1:0] wrap;
    logic [N-1:0] restart;
    logic         wr_ok;
    logic         err_d;

    // Write is legal only for an existing channel with a nonzero period and high <= period.
    always_comb begin
        wr_ok = cfg_we && (32'(cfg_ch) < N) && (cfg_period != '0) && (cfg_high <= cfg_period);
        err_d = cfg_we && !wr_ok;
    end

    // Per-channel next state; apply uses the pre-edge shadow so a same-edge write stays pending.
    always_comb begin
        wrap    = '0;
        restart = '0;
        pend_d  = pend;
        gen_d   = '0;
        tick_d  = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_d[i]  = cnt_q[i];
            per_d[i]  = per_q[i];
            hi_d[i]   = hi_q[i];
            sper_d[i] = sper_q[i];
            shi_d[i]  = shi_q[i];

            wrap[i]    = act_q[i] && (cnt_q[i] == (per_q[i] - W'(1)));
            restart[i] = cfg_sync || !ena[i] || !act_q[i] || wrap[i];

            if (pend[i] && restart[i]) begin
                per_d[i]  = sper_q[i];
                hi_d[i]   = shi_q[i];
                pend_d[i] = 1'b0;
            end

            cnt_d[i] = restart[i] ? '0 : (cnt_q[i] + W'(1));

            if (wr_ok && (cfg_ch == CW'(i))) begin
                sper_d[i] = cfg_period;
                shi_d[i]  = cfg_high;
                pend_d[i] = 1'b1;
            end

            gen_d[i]  = ena[i] && (cnt_d[i] < hi_d[i]);
            tick_d[i] = ena[i] && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i]  <= '0;
                per_q[i]  <= DEF_PERIOD;
                hi_q[i]   <= DEF_HIGH;
                sper_q[i] <= DEF_PERIOD;
                shi_q[i]  <= DEF_HIGH;
            end
            act_q   <= '0;
            pend    <= '0;
            gen     <= '0;
            tick    <= '0;
            cfg_err <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i]  <= cnt_d[i];
                per_q[i]  <= per_d[i];
                hi_q[i]   <= hi_d[i];
                sper_q[i] <= sper_d[i];
                shi_q[i]  <= shi_d[i];
            end
            act_q   <= ena;
            pend    <= pend_d;
            gen     <= gen_d;
            tick    <= tick_d;
            cfg_err <= err_d;
        end
    end

endmodule

// File: tb/tb_clkgen_bank.sv
// Directed and randomized bench for clkgen_bank against a per-channel phase model.
module tb_clkgen_bank;

    localparam int unsigned N  = 2;
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 1;
    localparam int unsigned DP = 10;
    localparam int unsigned DH = 5;

    logic          clk = 1'b0;
    logic          rst_;
    logic [N-1:0]  ena;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_period;
    logic [W-1:0]  cfg_high;
    logic          cfg_sync;
    logic          cfg_err;
    logic [N-1:0]  pend;
    logic [N-1:0]  gen;
    logic [N-1:0]  tick;

    int errors = 0;
    int checks = 0;

    // Reference model: phase within period, live and shadow config, enable history.
    int unsigned m_per [N];
    int unsigned m_hi  [N];
    int unsigned s_per [N];
    int unsigned s_hi  [N];
    int unsigned m_pos [N];
    bit          m_pend[N];
    bit          m_act [N];
    bit          m_err;

    clkgen_bank #(
        .N(N), .W(W), .DEF_PERIOD(W'(DP)), .DEF_HIGH(W'(DH))
    ) dut (
        .clk(clk), .rst_(rst_), .ena(ena), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_sync(cfg_sync),
        .cfg_err(cfg_err), .pend(pend), .gen(gen), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int c = 0; c < int'(N); c++) begin
            m_per[c] = DP; m_hi[c] = DH; s_per[c] = DP; s_hi[c] = DH;
            m_pos[c] = 0;  m_pend[c] = 1'b0; m_act[c] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] eg, et, ep;
        for (int c = 0; c < int'(N); c++) begin
            eg[c] = m_act[c] && (m_pos[c] < m_hi[c]);
            et[c] = m_act[c] && (m_pos[c] == 0);
            ep[c] = m_pend[c];
        end
        chk({tag, ".gen"},  32'(gen),     32'(eg));
        chk({tag, ".tick"}, 32'(tick),    32'(et));
        chk({tag, ".pend"}, 32'(pend),    32'(ep));
        chk({tag, ".err"},  32'(cfg_err), 32'(m_err));
    endtask

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic cyc(input string tag);
        bit ok;
        bit wrap;
        bit brk;
        @(posedge clk);
        if (!rst_) begin
            mreset();
        end else begin
            ok = cfg_we && (int'(cfg_ch) < int'(N)) && (cfg_period != 0) && (cfg_high <= cfg_period);
            for (int c = 0; c < int'(N); c++) begin
                wrap = m_act[c] && ((m_pos[c] + 1) == m_per[c]);
                brk  = cfg_sync || !ena[c] || !m_act[c] || wrap;
                if (m_pend[c] && brk) begin
                    m_per[c] = s_per[c]; m_hi[c] = s_hi[c]; m_pend[c] = 1'b0;
                end
                m_pos[c] = brk ? 0 : m_pos[c] + 1;
                if (ok && (int'(cfg_ch) == c)) begin
                    s_per[c] = cfg_period; s_hi[c] = cfg_high; m_pend[c] = 1'b1;
                end
                m_act[c] = ena[c];
            end
            m_err = cfg_we && !ok;
        end
        #1;
        check_outputs(tag);
        cfg_we   = 1'b0;
        cfg_sync = 1'b0;
    endtask

    task automatic wr(input int ch, input int per, input int hi);
        cfg_we     = 1'b1;
        cfg_ch     = CW'(ch);
        cfg_period = W'(per);
        cfg_high   = W'(hi);
    endtask

    initial begin
        rst_ = 1'b0; ena = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_high = '0; cfg_sync = 1'b0;
        mreset();
        #12;
        check_outputs("reset");
        chk("reset.gen_const", 32'(gen), 32'd0);
        @(posedge clk); #1;
        rst_ = 1'b1;
        ena  = 2'b01;

        // Default 10-cycle / 5-high waveform on ch0 only.
        repeat (25) cyc("t1");

        // Mid-period reprogram of ch0 to period 4, high 1.
        wr(0, 4, 1);
        cyc("t2.wr");
        repeat (20) cyc("t2");

        // Rejected writes: zero period, then high above period.
        wr(0, 0, 0);
        cyc("t3.zero");
        repeat (2) cyc("t3");
        wr(0, 6, 7);
        cyc("t3.hi");
        repeat (2) cyc("t3");
        wr(1, 0, 3);
        cyc("t3.ch1");
        repeat (6) cyc("t3");

        // Period 1 with high 1 on ch1 and high 0 on ch0.
        ena = 2'b11;
        wr(1, 1, 1);
        cyc("t4.w1");
        repeat (4) cyc("t4");
        wr(0, 1, 0);
        cyc("t4.w0");
        repeat (8) cyc("t4");

        // Different phases, then cfg_sync aligns both channels.
        wr(0, 7, 3);
        cyc("t5.w0");
        wr(1, 5, 2);
        cyc("t5.w1");
        repeat (13) cyc("t5.run");
        cfg_sync = 1'b1;
        cyc("t5.sync");
        chk("t5.sync_tick", 32'(tick), 32'd3);
        repeat (15) cyc("t5.after");

        // Sync and write on the same edge: old shadow applied, new write pending.
        wr(0, 3, 2);
        cyc("t5b.w");
        wr(0, 8, 8);
        cfg_sync = 1'b1;
        cyc("t5b.both");
        repeat (10) cyc("t5b");

        // Drop ena[0] with a pending write, then re-enable.
        repeat (3) cyc("t6.pre");
        wr(0, 6, 4);
        cyc("t6.wr");
        ena = 2'b10;
        cyc("t6.drop");
        repeat (3) cyc("t6.off");
        ena = 2'b11;
        repeat (14) cyc("t6.on");

        // Asynchronous reset between edges.
        #2;
        rst_ = 1'b0;
        #1;
        mreset();
        check_outputs("t6.async");
        cyc("t6.hold");
        rst_ = 1'b1;
        repeat (12) cyc("t6.rel");

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) ena = N'($urandom);
            if ($urandom_range(0, 5) == 0)
                wr(int'($urandom_range(0, 1)), int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
            if ($urandom_range(0, 40) == 0) cfg_sync = 1'b1;
            cyc("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
